kugelblitz_frame_patch: RTL

KUGELBLITZ_FRAME_PATCH -- requirements
Module: kugelblitz_frame_patch

---
 rtl/kugelblitz_frame_patch.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/kugelblitz_frame_patch.sv
// Streams 512-bit frames through one register stage, overwriting one byte per frame from a queue of patch commands.
// Optional feature: define KG_PATCH_MISS_CNT_EN to enable the saturating miss_count counter.
module kugelblitz_frame_patch #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int OFFSET_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OFFSET_WIDTH-1:0]       cmd_offset,
    input  logic [7:0]                    cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          patch_applied,
    output logic                          patch_missed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   miss_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = OFFSET_WIDTH - 6;

    if (DATA_WIDTH != 512 || KEEP_WIDTH * 8 != DATA_WIDTH || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || OFFSET_WIDTH <= 6) begin : g_param_check
        $error("kugelblitz_frame_patch: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ARMED, PASS} state_t;

    state_t                  state, state_next;
    logic [BW-1:0]           beat_cnt;
    logic [OFFSET_WIDTH-1:0] fifo_offset [FIFO_DEPTH];
    logic [7:0]              fifo_data   [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [OFFSET_WIDTH-1:0] act_offset, eff_offset;
    logic [7:0]              act_data, eff_data;
    logic                    full, empty, push, pop, accept;
    logic                    armed, hit, miss;
    logic [5:0]              lane;
    logic [DATA_WIDTH-1:0]   patched;

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign pop           = accept & (state == IDLE) & ~empty;
    assign cmd_ready     = ~full | pop;
    assign push          = cmd_valid & cmd_ready;
    assign fifo_count    = count;

    // The first beat of a frame is judged against the FIFO head directly, before it lands in act_*.
    always_comb begin
        eff_offset = act_offset;
        eff_data   = act_data;
        armed      = (state == ARMED);
        if (state == IDLE) begin
            eff_offset = fifo_offset[rd_ptr];
            eff_data   = fifo_data[rd_ptr];
            armed      = ~empty;
        end
        lane    = eff_offset[5:0];
        hit     = armed && (beat_cnt == eff_offset[OFFSET_WIDTH-1:6]) && s_axis_tkeep[lane];
        miss    = armed && s_axis_tlast && !hit;
        patched = s_axis_tdata;
        if (hit) begin
            patched[{lane, 3'b000} +: 8] = eff_data;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (s_axis_tlast) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:    state_next = (!empty && !hit) ? ARMED : PASS;
                    ARMED:   state_next = hit ? PASS : ARMED;
                    default: state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (s_axis_tlast) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_offset[wr_ptr] <= cmd_offset;
            fifo_data[wr_ptr]   <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            act_offset <= '0;
            act_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                act_offset <= fifo_offset[rd_ptr];
                act_data   <= fifo_data[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The pulses are registered so they line up with the output beat they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            patch_applied <= 1'b0;
            patch_missed  <= 1'b0;
        end else begin
            patch_applied <= accept & hit;
            patch_missed  <= accept & miss;
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= patched;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tuser  <= s_axis_tuser;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef KG_PATCH_MISS_CNT_EN
    logic [15:0] miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (patch_missed && miss_cnt != 16'hFFFF) begin
            miss_cnt <= miss_cnt + 1'b1;
        end
    end

    assign miss_count = miss_cnt;
`else
    assign miss_count = 16'd0;
`endif

endmodule
